// File: rtl/router_pkg.sv
// Shared constants for the router output-port FIFO: header field layout
// and a helper that pulls the payload length out of a header word.
package router_pkg;

    localparam int LEN_LSB = 2;   // LSB of payload-length field in a header
    localparam int LEN_W   = 6;   // width of payload-length field
    localparam int ADDR_W  = 2;   // destination-address field below the length

    // Payload length carried by an 8-bit header word
    function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_LSB +: LEN_W];
    endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Storage for the packet FIFO: DEPTH entries of {marker, data}, written
// synchronously and read combinationally so the top can register the word.
module router_fifo_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: contents are never cleared, pointers decide what is valid
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO. Stores each word with its header marker,
// delivers registered read data with a valid strobe, flags the parity word
// that closes each packet, and keeps occupancy / packet / error status.
import router_pkg::*;

module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int LEN_LSB  = router_pkg::LEN_LSB,
    parameter int LEN_W    = router_pkg::LEN_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     read_enb,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     pkt_last,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     pkt_count_reg;
    logic [LEN_W:0]    rem_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              data_valid_reg;
    logic              pkt_last_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic              clear;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W:0]   rd_word;
    logic              rd_marked;
    logic [LEN_W-1:0]  rd_len;
    logic              pkt_inc;
    logic              pkt_dec;

    assign clear     = reset | soft_reset;
    // Acceptance uses the flags from the current (pre-edge) count
    assign wr_acc    = write_enb && !full;
    assign rd_acc    = read_enb && !empty;
    assign rd_marked = rd_word[DATA_W];
    assign rd_len    = rd_word[LEN_LSB +: LEN_W];
    assign pkt_inc   = wr_acc && lfd_state;
    assign pkt_dec   = rd_acc && rd_marked;

    router_fifo_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (wr_acc && !clear),
        .waddr (wr_ptr_reg),
        .wdata ({lfd_state, data_in}),
        .raddr (rd_ptr_reg),
        .rdata (rd_word)
    );

    // Pointers and occupancy
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Headers queued but not yet read
    always_ff @(posedge clock) begin
        if (clear) begin
            pkt_count_reg <= '0;
        end else if (pkt_inc && !pkt_dec) begin
            pkt_count_reg <= pkt_count_reg + CW'(1);
        end else if (pkt_dec && !pkt_inc) begin
            pkt_count_reg <= pkt_count_reg - CW'(1);
        end
    end

    // Registered read data, valid strobe and end-of-packet tracking
    always_ff @(posedge clock) begin
        if (clear) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            pkt_last_reg   <= 1'b0;
            rem_reg        <= '0;
        end else if (rd_acc) begin
            data_out_reg   <= rd_word[DATA_W-1:0];
            data_valid_reg <= 1'b1;
            if (rd_marked) begin
                // Header (re)loads payload + parity; a truncated packet just restarts
                rem_reg      <= {1'b0, rd_len} + (LEN_W+1)'(1);
                pkt_last_reg <= 1'b0;
            end else begin
                pkt_last_reg <= (rem_reg == (LEN_W+1)'(1));
                if (rem_reg != '0) rem_reg <= rem_reg - (LEN_W+1)'(1);
            end
        end else begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            pkt_last_reg   <= 1'b0;
        end
    end

    // Sticky error flags for rejected requests
    always_ff @(posedge clock) begin
        if (clear) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (write_enb && full) overflow_reg  <= 1'b1;
            if (read_enb && empty) underflow_reg <= 1'b1;
        end
    end

    assign full        = (count_reg == CW'(DEPTH));
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= CW'(AF_LEVEL));
    assign count       = count_reg;
    assign pkt_count   = pkt_count_reg;
    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign pkt_last    = pkt_last_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

endmodule
